gpio_tx_arbiter: RTL

GPIO_TX_ARBITER -- requirements
Module: gpio_tx_arbiter

---
 rtl/gpio_tx_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/gpio_tx_arbiter.sv
// rtl/gpio_tx_arbiter.sv - two-requester round-robin serialiser onto a slow gpio link
// Optional feature: define GPIO_PARITY_EN to append an odd-parity cell to every frame.
module gpio_tx_arbiter #(
  parameter int HALF_PERIOD = 5000,
  parameter int DATA_W      = 8
) (
  input  logic              FPGA_clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              gpio_clock,
  output logic              gpio_data,
  output logic              gpio_frame,
  output logic              busy
);

`ifdef GPIO_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_W = DATA_W + PAR_W;
  localparam int CNT_W   = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam int BC_W    = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clk_q, clk_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]    bits_left_q, bits_left_d;
  logic               data_q, data_d;
  logic               frame_q, frame_d;
  logic               gnt_a_q, gnt_a_d;
  logic               gnt_b_q, gnt_b_d;
  logic               busy_q, busy_d;
  logic               last_b_q, last_b_d;

  logic               half_end;
  logic               fall_evt;
  logic               pick_b;
  logic [DATA_W-1:0]  win_data;
  logic [FRAME_W-1:0] frame_word;

  assign half_end = (cnt_q == CNT_W'(HALF_PERIOD - 1));
  assign fall_evt = half_end && clk_q;

  // B wins when it is the only requester, or on a tie when A was served last
  assign pick_b   = req_b && (!req_a || !last_b_q);
  assign win_data = pick_b ? data_b : data_a;

`ifdef GPIO_PARITY_EN
  // odd parity: the appended cell makes the total count of ones odd
  assign frame_word = {win_data, ~^win_data};
`else
  assign frame_word = win_data;
`endif

  // next-state logic: link clock divider, arbitration and serialisation, all paced by fall events
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    clk_d       = clk_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    data_d      = data_q;
    frame_d     = frame_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    last_b_d    = last_b_q;

    if (half_end) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end

    if (fall_evt) begin
      case (state_q)
        IDLE: begin
          if (req_a || req_b) begin
            state_d     = SHIFT;
            gnt_a_d     = !pick_b;
            gnt_b_d     = pick_b;
            last_b_d    = pick_b;
            data_d      = frame_word[FRAME_W-1];
            shreg_d     = frame_word << 1;
            bits_left_d = BC_W'(FRAME_W - 1);
            frame_d     = 1'b1;
          end
        end
        SHIFT: begin
          if (bits_left_q == '0) begin
            state_d = GAP;
            frame_d = 1'b0;
            data_d  = 1'b0;
          end else begin
            data_d      = shreg_q[FRAME_W-1];
            shreg_d     = shreg_q << 1;
            bits_left_d = bits_left_q - BC_W'(1);
          end
        end
        GAP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          frame_d = 1'b0;
          data_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // state and registered outputs; reset aborts any frame in flight
  always_ff @(posedge FPGA_clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clk_q       <= 1'b0;
      shreg_q     <= '0;
      bits_left_q <= '0;
      data_q      <= 1'b0;
      frame_q     <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      last_b_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_q       <= clk_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      data_q      <= data_d;
      frame_q     <= frame_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      busy_q      <= busy_d;
      last_b_q    <= last_b_d;
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign gpio_clock = clk_q;
  assign gpio_data  = data_q;
  assign gpio_frame = frame_q;
  assign busy       = busy_q;

endmodule
